// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed 32-bit multiply/divide execution unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle. The sign is applied and exceptions are detected in
// the DONE cycle. Results are registered on the DONE -> IDLE edge.
// Optional feature macro: MULTDIV_EARLY_OUT_EN. When it is defined, a
// multiply by zero or a divide by zero bypasses iteration (IDLE -> DONE).
module multdiv_unit #(
    parameter int unsigned MUL_EXC_CODE = 4,
    parameter int unsigned DIV_EXC_CODE = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_mul,
    input  logic               start_div,
    input  logic signed [31:0] operand_a,
    input  logic signed [31:0] operand_b,
    input  logic [4:0]         dest_reg,
    input  logic               kill,
    output logic               busy,
    output logic               result_ready,
    output logic [31:0]        result,
    output logic [4:0]         result_reg,
    output logic               exception,
    output logic [31:0]        exc_code
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [4:0] STATUS_REG = 5'd30;

    // Absolute value as an unsigned word. 0x80000000 maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic signed [31:0] v);
        logic [31:0] u;
        u = v;
        return u[31] ? (~u + 32'd1) : u;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // The product overflows when the upper word is not the sign extension of the lower word.
    function automatic logic mul_overflow(input logic [63:0] p);
        return p[63:31] != {33{p[31]}};
    endfunction

    // Control state (reset)
    state_t      state_q, state_d;
    logic [4:0]  counter_q, counter_d;
    logic        result_ready_q, result_ready_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  result_reg_q, result_reg_d;
    logic        exception_q, exception_d;
    logic [31:0] exc_code_q, exc_code_d;

    // Datapath state (no reset)
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] opnd_q, opnd_d;     // multiplicand magnitude, or divisor magnitude
    logic [63:0] acc_q, acc_d;       // {partial product | multiplier} or {remainder | dividend/quotient}

    // One iteration of each algorithm
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rem;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;

    // Completion values
    logic [63:0] prod_signed;
    logic [31:0] quot_signed;
    logic        fin_exc;
    logic [31:0] fin_res;
    logic [31:0] fin_code;

    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    assign div_rem  = acc_q[63:31];
    assign div_ge   = div_rem >= {1'b0, opnd_q};
    assign div_diff = div_rem[31:0] - opnd_q;
    assign div_next = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                             : {div_rem[31:0], acc_q[30:0], 1'b0};

    assign prod_signed = cond_neg64(acc_q, neg_q);
    assign quot_signed = cond_neg32(acc_q[31:0], neg_q);

    // Sign application and exception detection for the finished operation
    always_comb begin
        fin_exc  = 1'b0;
        fin_res  = 32'd0;
        fin_code = 32'd0;
        if (is_div_q) begin
            if (opnd_q == 32'd0) begin
                fin_exc = 1'b1;
                fin_res = 32'd0;
            end else begin
                // Only 0x80000000 / -1 yields an unsigned quotient of 2^31 with a positive sign.
                fin_exc = !neg_q && acc_q[31];
                fin_res = quot_signed;
            end
            if (fin_exc) fin_code = 32'(DIV_EXC_CODE);
        end else begin
            fin_exc = mul_overflow(prod_signed);
            fin_res = prod_signed[31:0];
            if (fin_exc) fin_code = 32'(MUL_EXC_CODE);
        end
    end

    // Next-state, iteration and writeback logic
    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        result_ready_d = 1'b0;
        result_d       = result_q;
        result_reg_d   = result_reg_q;
        exception_d    = exception_q;
        exc_code_d     = exc_code_q;
        is_div_d       = is_div_q;
        neg_d          = neg_q;
        dest_d         = dest_q;
        opnd_d         = opnd_q;
        acc_d          = acc_q;
        case (state_q)
            IDLE: begin
                if (!kill && (start_mul || start_div)) begin
                    counter_d = 5'd0;
                    dest_d    = dest_reg;
                    neg_d     = operand_a[31] ^ operand_b[31];
                    if (start_mul) begin
                        is_div_d = 1'b0;
                        opnd_d   = magnitude(operand_a);
                        acc_d    = {32'd0, magnitude(operand_b)};
                        state_d  = MUL;
`ifdef MULTDIV_EARLY_OUT_EN
                        if (operand_a == 32'sd0 || operand_b == 32'sd0) begin
                            acc_d   = 64'd0;
                            state_d = DONE;
                        end
`endif
                    end else begin
                        is_div_d = 1'b1;
                        opnd_d   = magnitude(operand_b);
                        acc_d    = {32'd0, magnitude(operand_a)};
                        state_d  = DIV;
`ifdef MULTDIV_EARLY_OUT_EN
                        if (operand_b == 32'sd0) state_d = DONE;
`endif
                    end
                end
            end
            MUL, DIV: begin
                if (kill) begin
                    state_d   = IDLE;
                    counter_d = 5'd0;
                end else begin
                    acc_d     = (state_q == DIV) ? div_next : mul_next;
                    counter_d = counter_q + 5'd1;
                    if (counter_q == 5'd31) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!kill) begin
                    result_ready_d = 1'b1;
                    result_d       = fin_res;
                    result_reg_d   = fin_exc ? STATUS_REG : dest_q;
                    exception_d    = fin_exc;
                    exc_code_d     = fin_code;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            counter_q      <= 5'd0;
            result_ready_q <= 1'b0;
            result_q       <= 32'd0;
            result_reg_q   <= 5'd0;
            exception_q    <= 1'b0;
            exc_code_q     <= 32'd0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            result_ready_q <= result_ready_d;
            result_q       <= result_d;
            result_reg_q   <= result_reg_d;
            exception_q    <= exception_d;
            exc_code_q     <= exc_code_d;
        end
    end

    // Operand and accumulator registers; only meaningful while busy
    always_ff @(posedge clock) begin
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        dest_q   <= dest_d;
        opnd_q   <= opnd_d;
        acc_q    <= acc_d;
    end

    assign busy         = (state_q != IDLE);
    assign result_ready = result_ready_q;
    assign result       = result_q;
    assign result_reg   = result_reg_q;
    assign exception    = exception_q;
    assign exc_code     = exc_code_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Testbench for multdiv_unit: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_multdiv_unit;

    logic               clock = 1'b0;
    logic               reset;
    logic               start_mul;
    logic               start_div;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    logic [4:0]         dest_reg;
    logic               kill;
    logic               busy;
    logic               result_ready;
    logic [31:0]        result;
    logic [4:0]         result_reg;
    logic               exception;
    logic [31:0]        exc_code;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] last_res  = 32'd0;
    logic [4:0]  last_reg  = 5'd0;
    logic        last_exc  = 1'b0;
    logic [31:0] last_code = 32'd0;

    multdiv_unit dut (
        .clock        (clock),
        .reset        (reset),
        .start_mul    (start_mul),
        .start_div    (start_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .dest_reg     (dest_reg),
        .kill         (kill),
        .busy         (busy),
        .result_ready (result_ready),
        .result       (result),
        .result_reg   (result_reg),
        .exception    (exception),
        .exc_code     (exc_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output bit exc);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] lo;
        logic signed [31:0] q;
        longint p;
        sa = a;
        sb = b;
        if (!is_div) begin
            p   = longint'(sa) * longint'(sb);
            lo  = p[31:0];
            res = p[31:0];
            exc = (p != longint'(lo));
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            q   = sa / sb;
            res = q;
            exc = 1'b0;
        end
    endfunction

    // Issue one operation at the current (negedge) time and check its completion.
    // A start_mul is poked while busy at cycle poke_at (negative: none).
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int poke_at);
        logic [31:0] exp_res;
        bit          exp_exc;
        int          exp_lat;
        int          got_lat;
        int          busy_cnt;
        model(is_div, a, b, exp_res, exp_exc);
        exp_lat = 33;
`ifdef MULTDIV_EARLY_OUT_EN
        if ((!is_div && (a == 32'd0 || b == 32'd0)) || (is_div && b == 32'd0)) exp_lat = 1;
`endif
        start_mul = !is_div;
        start_div = is_div;
        operand_a = a;
        operand_b = b;
        dest_reg  = rd;
        @(posedge clock);
        got_lat  = -1;
        busy_cnt = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clock);
            if (j == 0) begin
                start_mul = 1'b0;
                start_div = 1'b0;
                operand_a = $urandom;
                operand_b = $urandom;
                dest_reg  = 5'($urandom);
            end
            if (busy) busy_cnt++;
            if (result_ready) begin
                got_lat = j;
                break;
            end
            start_mul = (j == poke_at);
        end
        start_mul = 1'b0;
        start_div = 1'b0;
        check("latency", got_lat, exp_lat);
        check("busy_cycles", busy_cnt, exp_lat);
        check("busy_at_ready", busy, 1'b0);
        check("result", result, exp_res);
        check("result_reg", result_reg, exp_exc ? 5'd30 : rd);
        check("exception", exception, exp_exc);
        if (exp_exc) check("exc_code", exc_code, is_div ? 32'd5 : 32'd4);
        last_res  = exp_res;
        last_reg  = exp_exc ? 5'd30 : rd;
        last_exc  = exp_exc;
        last_code = exp_exc ? (is_div ? 32'd5 : 32'd4) : exc_code;
    endtask

    // One cycle after writeback: strobe gone, outputs held.
    task automatic idle_check();
        @(negedge clock);
        check("ready_one_pulse", result_ready, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("result_hold", result, last_res);
        check("result_reg_hold", result_reg, last_reg);
        check("exception_hold", exception, last_exc);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'(int'($urandom_range(0, 2000)) - 1000);
            2:       return 32'd0;
            3:       return 32'hFFFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_seen;
        reset     = 1'b1;
        start_mul = 1'b0;
        start_div = 1'b0;
        operand_a = 32'sd0;
        operand_b = 32'sd0;
        dest_reg  = 5'd0;
        kill      = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", result_ready, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_result_reg", result_reg, 5'd0);
        check("rst_exception", exception, 1'b0);
        check("rst_exc_code", exc_code, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Directed operations
        run_op(1'b0, 32'd7, 32'hFFFF_FFFA, 5'd3, -1);
        idle_check();
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd12, -1);
        idle_check();
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9, -1);
        run_op(1'b1, 32'd5, 32'd0, 5'd11, -1);          // issued in the writeback cycle
        idle_check();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 5);
        idle_check();
        run_op(1'b0, 32'd0, 32'd12345, 5'd6, -1);
        idle_check();
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, -1);
        idle_check();

        // Kill during the multiply iterations
        ready_seen = 0;
        start_mul = 1'b1;
        operand_a = 32'sd3;
        operand_b = 32'sd9;
        dest_reg  = 5'd2;
        @(posedge clock);
        for (int j = 0; j <= 10; j++) begin
            @(negedge clock);
            if (j == 0) start_mul = 1'b0;
            if (result_ready) ready_seen++;
            if (j == 10) kill = 1'b1;
        end
        @(negedge clock);
        kill = 1'b0;
        check("kill_busy", busy, 1'b0);
        check("kill_ready", result_ready | (ready_seen != 0), 1'b0);
        check("kill_result_hold", result, last_res);
        check("kill_reg_hold", result_reg, last_reg);
        run_op(1'b1, 32'd1000, 32'hFFFF_FFFD, 5'd8, -1);
        idle_check();

        // Kill together with a start in IDLE: the start is dropped
        kill      = 1'b1;
        start_div = 1'b1;
        operand_a = 32'sd40;
        operand_b = 32'sd2;
        @(negedge clock);
        kill      = 1'b0;
        start_div = 1'b0;
        check("kill_start_busy", busy, 1'b0);
        @(negedge clock);
        check("kill_start_ready", result_ready, 1'b0);

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand(), 5'($urandom), -1);
            idle_check();
        end

        // Asynchronous reset in the middle of a multiply
        start_mul = 1'b1;
        operand_a = 32'sd1234;
        operand_b = 32'sd5678;
        dest_reg  = 5'd17;
        @(posedge clock);
        @(negedge clock);
        start_mul = 1'b0;
        repeat (20) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", result_ready, 1'b0);
        check("async_rst_result", result, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        check("post_rst_result_reg", result_reg, 5'd0);
        check("post_rst_exception", exception, 1'b0);
        check("post_rst_exc_code", exc_code, 32'd0);
        ready_seen = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            if (result_ready || busy) ready_seen++;
        end
        check("post_rst_quiet", ready_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
